// File: rtl/matmul_seq_ctrl.sv
// matmul_seq_ctrl: sequences a 4x4 fixed-point C = A x B over single-port A/B/C memories.
module matmul_seq_ctrl #(
  parameter int DW = 16,
  parameter int QF = 8
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic          abort,
  output logic          busy,
  output logic          done,
  output logic          rd_en,
  output logic [3:0]    a_addr,
  output logic [3:0]    b_addr,
  input  logic [DW-1:0] a_rdata,
  input  logic [DW-1:0] b_rdata,
  output logic          c_we,
  output logic [3:0]    c_addr,
  output logic [DW-1:0] c_wdata,
  output logic          ovf
);
  localparam int AW = 2*DW + 2;
  localparam logic signed [AW-1:0] SMAX = AW'(2**(DW-1) - 1);
  localparam logic signed [AW-1:0] SMIN = AW'(-(2**(DW-1)));
  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;
  state_t state, nxt;
  logic [6:0] cyc;
  logic [5:0] rc;
  logic vld;
  logic [1:0] dk;
  logic [3:0] de;
  logic signed [2*DW-1:0] full;
  logic signed [AW-1:0] acc, prod, sum;
  logic [DW-1:0] sat;
  logic go, kill, clip, wr;
  assign go = state == IDLE && start;
  assign kill = state != IDLE && abort;
  assign busy = state != IDLE;
  assign rd_en = state == RUN;
  // rc = {i, j, k}: element e = {i, j}, inner index k
  assign a_addr = {rc[5:4], rc[1:0]};
  assign b_addr = {rc[1:0], rc[3:2]};
  assign wr = vld && dk == 2'd3 && !kill;
  always_comb begin
    nxt = kill ? IDLE :
          go ? RUN :
          (state == RUN && cyc == 7'd64) ? DRAIN :
          (state == DRAIN && cyc == 7'd70) ? IDLE : state;
  end
  // k == 0 restarts the sum so the next element never waits on the previous one
  always_comb begin
    full = $signed(a_rdata) * $signed(b_rdata);
    prod = AW'(full >>> QF);
    sum = (dk == 2'd0 ? AW'(0) : acc) + prod;
    clip = sum > SMAX || sum < SMIN;
    sat = clip ? (sum[AW-1] ? SMIN[DW-1:0] : SMAX[DW-1:0]) : sum[DW-1:0];
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else state <= nxt;
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cyc <= '0;
      rc <= '0;
      vld <= 1'b0;
      dk <= '0;
      de <= '0;
      acc <= '0;
      c_we <= 1'b0;
      c_addr <= '0;
      c_wdata <= '0;
      ovf <= 1'b0;
      done <= 1'b0;
    end else begin
      cyc <= go ? 7'd1 : busy ? cyc + 7'd1 : cyc;
      rc <= go ? 6'd0 : (rd_en && cyc != 7'd64) ? rc + 6'd1 : rc;
      vld <= rd_en && !kill;
      dk <= rc[1:0];
      de <= rc[5:2];
      acc <= go ? AW'(0) : vld ? sum : acc;
      c_we <= wr;
      c_addr <= wr ? de : c_addr;
      c_wdata <= wr ? sat : c_wdata;
      ovf <= go ? 1'b0 : (wr && clip) ? 1'b1 : ovf;
      done <= state == DRAIN && cyc == 7'd70 && !kill;
    end
  end
endmodule
